// File: rtl/system_pkg.sv
// Shared constants for the binary CPU system: run-state encoding and the
// CPU fetch-state value.
package system_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOADING   = 2'd1,
        ST_EXECUTING = 2'd2,
        ST_HALTED    = 2'd3
    } sys_state_e;

    localparam logic [1:0]  CPU_FETCH_STATE = 2'd0;
    localparam logic [15:0] PC_RESET        = 16'hFFFF;

endpackage

// File: rtl/system_sequencer_halt_detector.sv
// Program-completion detector: PC unchanged at fetch for HALT_CYCLES
// consecutive EXECUTING cycles produces a one-cycle halted indication.
module halt_detector
    import system_pkg::*;
#(
    parameter int HALT_CYCLES = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        active,
    input  logic [15:0] cpu_pc,
    input  logic        cpu_fetch,
    output logic        halted
);

    localparam int CW = $clog2(HALT_CYCLES + 1);

    logic [15:0]   prev_pc_r;
    logic [CW-1:0] stable_cnt_r;
    logic          qualify_s;

    assign qualify_s = active && cpu_fetch && (cpu_pc == prev_pc_r);
    // Fires on the edge that would bring the count to HALT_CYCLES.
    assign halted    = qualify_s && (stable_cnt_r == CW'(HALT_CYCLES - 1));

    // Track previous PC and the saturating stable-cycle count; idle outside EXECUTING.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_pc_r    <= PC_RESET;
            stable_cnt_r <= {CW{1'b0}};
        end else if (!active) begin
            prev_pc_r    <= PC_RESET;
            stable_cnt_r <= {CW{1'b0}};
        end else begin
            prev_pc_r <= cpu_pc;
            if (!qualify_s) begin
                stable_cnt_r <= {CW{1'b0}};
            end else if (stable_cnt_r != CW'(HALT_CYCLES)) begin
                stable_cnt_r <= stable_cnt_r + CW'(1);
            end else begin
                stable_cnt_r <= stable_cnt_r;
            end
        end
    end

endmodule

// File: rtl/system_sequencer.sv
// Run controller IDLE -> LOADING -> EXECUTING -> HALTED with RAM port arbitration.
// Optional execution budget enabled by defining SYSTEM_SEQUENCER_TIMEOUT_EN.
module system_sequencer
    import system_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int HALT_CYCLES    = 5,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  loader_start,
    input  logic                  loader_done,
    input  logic                  loader_mem_write,
    input  logic [ADDR_WIDTH-1:0] loader_mem_addr,
    input  logic [DATA_WIDTH-1:0] loader_mem_wdata,
    input  logic                  cpu_mem_write,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_wdata,
    input  logic [15:0]           cpu_pc,
    input  logic                  cpu_fetch,
    output logic                  cpu_run,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [1:0]            system_state,
    output logic                  done,
    output logic                  timeout
);

    sys_state_e state_r;
    logic       loader_start_r;
    logic       cpu_run_r;
    logic       done_r;
    logic       timeout_r;
    logic       halted_s;
    logic       timeout_hit_s;

    halt_detector #(.HALT_CYCLES(HALT_CYCLES)) u_halt_detector (
        .clock     (clock),
        .reset_n   (reset_n),
        .active    (state_r == ST_EXECUTING),
        .cpu_pc    (cpu_pc),
        .cpu_fetch (cpu_fetch),
        .halted    (halted_s)
    );

`ifdef SYSTEM_SEQUENCER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] cycle_cnt_r;

    // Count EXECUTING cycles; cleared whenever the CPU is not running.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_r <= {TW{1'b0}};
        end else if (state_r != ST_EXECUTING) begin
            cycle_cnt_r <= {TW{1'b0}};
        end else if (cycle_cnt_r != TW'(TIMEOUT_CYCLES)) begin
            cycle_cnt_r <= cycle_cnt_r + TW'(1);
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign timeout_hit_s = (state_r == ST_EXECUTING) &&
                           (cycle_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Run-state machine with registered control outputs; halt outranks timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            loader_start_r <= 1'b0;
            cpu_run_r      <= 1'b0;
            done_r         <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            loader_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r        <= ST_LOADING;
                        loader_start_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOADING: begin
                    if (loader_done) begin
                        state_r   <= ST_EXECUTING;
                        cpu_run_r <= 1'b1;
                    end else begin
                        state_r <= ST_LOADING;
                    end
                end
                ST_EXECUTING: begin
                    if (halted_s) begin
                        state_r   <= ST_HALTED;
                        cpu_run_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else if (timeout_hit_s) begin
                        state_r   <= ST_HALTED;
                        cpu_run_r <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        state_r <= ST_EXECUTING;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        state_r        <= ST_LOADING;
                        loader_start_r <= 1'b1;
                        done_r         <= 1'b0;
                        timeout_r      <= 1'b0;
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cpu_run_r <= 1'b0;
                end
            endcase
        end
    end

    // RAM port owner follows the registered state with no added latency.
    always_comb begin
        ram_write = 1'b0;
        ram_addr  = {ADDR_WIDTH{1'b0}};
        ram_wdata = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_LOADING: begin
                ram_write = loader_mem_write;
                ram_addr  = loader_mem_addr;
                ram_wdata = loader_mem_wdata;
            end
            ST_EXECUTING: begin
                ram_write = cpu_mem_write;
                ram_addr  = cpu_mem_addr;
                ram_wdata = cpu_mem_wdata;
            end
            default: begin
                ram_write = 1'b0;
                ram_addr  = {ADDR_WIDTH{1'b0}};
                ram_wdata = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    assign system_state = state_r;
    assign loader_start = loader_start_r;
    assign cpu_run      = cpu_run_r;
    assign done         = done_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_system_sequencer.sv
// Directed bench for system_sequencer: expectations are queued with each
// stimulus step and popped against the DUT outputs after the clock edge.
module tb_system_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        loader_start;
    logic        loader_done;
    logic        loader_mem_write;
    logic [15:0] loader_mem_addr;
    logic [15:0] loader_mem_wdata;
    logic        cpu_mem_write;
    logic [15:0] cpu_mem_addr;
    logic [15:0] cpu_mem_wdata;
    logic [15:0] cpu_pc;
    logic        cpu_fetch;
    logic        cpu_run;
    logic        ram_write;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [1:0]  system_state;
    logic        done;
    logic        timeout;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    system_sequencer #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (16),
        .HALT_CYCLES    (5),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .loader_start     (loader_start),
        .loader_done      (loader_done),
        .loader_mem_write (loader_mem_write),
        .loader_mem_addr  (loader_mem_addr),
        .loader_mem_wdata (loader_mem_wdata),
        .cpu_mem_write    (cpu_mem_write),
        .cpu_mem_addr     (cpu_mem_addr),
        .cpu_mem_wdata    (cpu_mem_wdata),
        .cpu_pc           (cpu_pc),
        .cpu_fetch        (cpu_fetch),
        .cpu_run          (cpu_run),
        .ram_write        (ram_write),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .system_state     (system_state),
        .done             (done),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] obs_of(string tag);
        case (tag)
            "state":  return {30'd0, system_state};
            "lstart": return {31'd0, loader_start};
            "run":    return {31'd0, cpu_run};
            "done":   return {31'd0, done};
            "tmo":    return {31'd0, timeout};
            "rwr":    return {31'd0, ram_write};
            "raddr":  return {16'd0, ram_addr};
            "rwd":    return {16'd0, ram_wdata};
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(string tag, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_ctl(logic [1:0] st, logic ls, logic run, logic dn, logic tm);
        expect_val("state", {30'd0, st});
        expect_val("lstart", {31'd0, ls});
        expect_val("run", {31'd0, run});
        expect_val("done", {31'd0, dn});
        expect_val("tmo", {31'd0, tm});
    endtask

    task automatic expect_ram(logic wr, logic [15:0] a, logic [15:0] d);
        expect_val("rwr", {31'd0, wr});
        expect_val("raddr", {16'd0, a});
        expect_val("rwd", {16'd0, d});
    endtask

    task automatic drain(string where);
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs_of(e.tag);
            total++;
            assert (o === e.val)
            else begin
                bad++;
                $error("FAIL %s/%s observed=%0h expected=%0h", where, e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        loader_done = 1'b0;
        loader_mem_write = 1'b0;
        loader_mem_addr = 16'h0000;
        loader_mem_wdata = 16'h0000;
        cpu_mem_write = 1'b0;
        cpu_mem_addr = 16'h0000;
        cpu_mem_wdata = 16'h0000;
        cpu_pc = 16'h0000;
        cpu_fetch = 1'b0;

        // Reset values.
        tick();
        tick();
        expect_ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_ram(1'b0, 16'h0000, 16'h0000);
        drain("reset");
        reset_n = 1'b1;
        tick();

        // Start -> LOADING with a one-cycle loader_start.
        start = 1'b1;
        expect_ctl(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drain("start");
        start = 1'b0;
        loader_mem_write = 1'b1;
        loader_mem_addr = 16'h0003;
        loader_mem_wdata = 16'h1234;
        cpu_mem_write = 1'b1;
        cpu_mem_addr = 16'h0077;
        cpu_mem_wdata = 16'hBEEF;
        #1;
        expect_ram(1'b1, 16'h0003, 16'h1234);
        drain("load_mux");
        for (int i = 0; i < 7; i++) begin
            expect_ctl(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            drain("loading");
        end

        // loader_done -> EXECUTING; CPU now owns the port.
        loader_done = 1'b1;
        expect_ctl(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_ram(1'b1, 16'h0077, 16'hBEEF);
        tick();
        drain("exec_entry");
        loader_done = 1'b0;
        cpu_mem_write = 1'b0;
        #1;
        expect_val("rwr", 32'd0);
        drain("exec_loader_blocked");
        loader_mem_write = 1'b0;

        // Halt detect with one PC change restarting the count.
        cpu_fetch = 1'b1;
        cpu_pc = 16'd12;
        for (int i = 0; i < 3; i++) begin
            expect_ctl(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            drain("halt_pre");
        end
        cpu_pc = 16'd13;
        for (int i = 0; i < 5; i++) begin
            expect_ctl(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            drain("halt_restart");
        end
        expect_ctl(2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drain("halted1");
        cpu_mem_write = 1'b1;
        cpu_mem_addr = 16'h0055;
        #1;
        expect_ram(1'b0, 16'h0000, 16'h0000);
        drain("halted_mux");
        cpu_mem_write = 1'b0;
        expect_ctl(2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drain("halted_sticky");

        // Rerun: loader_done coincident with loader_start is honoured.
        start = 1'b1;
        expect_ctl(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drain("rerun_start");
        start = 1'b0;
        loader_done = 1'b1;
        cpu_pc = 16'd12;
        expect_ctl(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drain("rerun_exec");
        loader_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_ctl(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            drain("rerun_count");
        end
        expect_ctl(2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drain("halted2");

        // Reset mid-EXECUTING kills a CPU write immediately.
        start = 1'b1;
        tick();
        start = 1'b0;
        loader_done = 1'b1;
        cpu_pc = 16'd0;
        tick();
        loader_done = 1'b0;
        cpu_mem_write = 1'b1;
        cpu_mem_addr = 16'h0005;
        cpu_mem_wdata = 16'hA5A5;
        #1;
        expect_ram(1'b1, 16'h0005, 16'hA5A5);
        drain("pre_reset_write");
        #1;
        reset_n = 1'b0;
        #1;
        expect_ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_ram(1'b0, 16'h0000, 16'h0000);
        drain("async_reset");
        cpu_mem_write = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

`ifdef SYSTEM_SEQUENCER_TIMEOUT_EN
        // Ever-changing PC runs out the 20-cycle budget.
        start = 1'b1;
        tick();
        start = 1'b0;
        loader_done = 1'b1;
        tick();
        loader_done = 1'b0;
        for (int i = 0; i < 19; i++) begin
            cpu_pc = cpu_pc + 16'd1;
            expect_ctl(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            drain("tmo_run");
        end
        cpu_pc = cpu_pc + 16'd1;
        expect_ctl(2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drain("tmo_hit");
        start = 1'b1;
        expect_ctl(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drain("tmo_clear");
        start = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/system_sequencer.md
# system_sequencer

Top-level run controller for the binary CPU system. It sequences the power-on flow IDLE → LOADING → EXECUTING → HALTED and owns the single RAM write/address port, granting it to the program loader during LOADING and to the CPU during EXECUTING. It also detects program completion in hardware (PC stable at fetch for HALT_CYCLES consecutive cycles), replacing bench-side polling. It sits in `system` between `loader`, `cpu` and `ram`.

## Interface
- ADDR_WIDTH, 16, RAM address width
- DATA_WIDTH, 16, RAM data width
- HALT_CYCLES, 5, consecutive stable-PC fetch cycles that declare completion (≥1)
- TIMEOUT_CYCLES, 1000, EXECUTING-cycle budget (used only with timeout feature)

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled each rising edge
- loader_start  out  1  one-cycle pulse starting the loader
- loader_done  in  1  loader finished writing program
- loader_mem_write  in  1  loader write strobe
- loader_mem_addr  in  ADDR_WIDTH  loader address
- loader_mem_wdata  in  DATA_WIDTH  loader write data
- cpu_mem_write  in  1  CPU write strobe
- cpu_mem_addr  in  ADDR_WIDTH  CPU address
- cpu_mem_wdata  in  DATA_WIDTH  CPU write data
- cpu_pc  in  16  CPU program counter
- cpu_fetch  in  1  CPU is in fetch state (state 0)
- cpu_run  out  1  CPU clock-enable; high only in EXECUTING
- ram_write  out  1  RAM write strobe
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- system_state  out  2  IDLE=0, LOADING=1, EXECUTING=2, HALTED=3
- done  out  1  program completed (sticky until next run)
- timeout  out  1  execution budget exhausted (sticky until next run)

## Operation
- Reset: state IDLE; loader_start, cpu_run, done, timeout = 0; prev_pc = 16'hFFFF; stable count = 0; cycle count = 0.
- IDLE: start=1 → LOADING.
- LOADING: loader_done=1 → EXECUTING; start ignored.
- EXECUTING: stable-count reaches HALT_CYCLES → HALTED, done=1; start ignored.
- HALTED: start=1 → LOADING; done and timeout clear on that transition.
- Halt detect (EXECUTING only): each cycle with cpu_fetch=1 and cpu_pc==prev_pc increments stable count (saturating, width $clog2(HALT_CYCLES+1)); any other cycle clears it. prev_pc loads cpu_pc every EXECUTING cycle; prev_pc reloads 16'hFFFF and count clears on entry to EXECUTING.
- Port mux (combinational from registered state): LOADING → loader signals; EXECUTING → CPU signals; IDLE/HALTED → ram_write=0, addr/wdata=0. Loader strobes outside LOADING and CPU strobes outside EXECUTING never reach RAM.
- Reset asserted mid-LOADING or mid-EXECUTING: immediate return to reset values; no partial write propagates once reset_n is low.

## Timing
- start sampled at edge N → system_state=LOADING and loader_start=1 after edge N; loader_start low after edge N+1.
- loader_done at edge M → EXECUTING and cpu_run=1 after edge M; loader_done on the same edge as loader_start is honoured.
- Halt: final qualifying cycle at edge K → HALTED, done=1, cpu_run=0 after edge K.
- Mux latency zero relative to state register.
- All outputs registered except ram_* (mux).

## Configuration
- SYSTEM_SEQUENCER_TIMEOUT_EN defined: cycle counter counts EXECUTING cycles; reaching TIMEOUT_CYCLES → HALTED with timeout=1, done=0. Halt and timeout on the same edge: halt wins (done=1, timeout=0). Counter clears on entry to EXECUTING.
- Not defined: no counter; timeout tied 0; EXECUTING exits only via halt detect or reset.

## Structure
- Shared package `system_pkg`: state encoding constants (IDLE, LOADING, EXECUTING, HALTED), CPU fetch state value 0.
- One sub-module natural: `halt_detector` (prev_pc register + saturating stable counter, outputs halted pulse).

## Test plan
- Reset, start pulse, loader_done after 8 cycles → states 0→1→2; loader_start high exactly one cycle; cpu_run high from EXECUTING entry.
- LOADING with loader_mem_write=1, addr=16'h0003, data=16'h1234; cpu_mem_write=1 concurrently → RAM sees only loader write; in EXECUTING, reverse holds.
- EXECUTING, cpu_pc held at 16'd12 with cpu_fetch=1 → done=1, state=3 after exactly 5 stable cycles; a single PC change at cycle 3 restarts the count.
- HALTED, start=1 → LOADING, done=0, second program runs to completion.
- reset_n low mid-EXECUTING with cpu_mem_write=1 → ram_write=0 immediately, all outputs at reset values.
- With SYSTEM_SEQUENCER_TIMEOUT_EN, TIMEOUT_CYCLES=20, PC always incrementing → timeout=1, done=0, state=3 after 20 EXECUTING cycles.
